// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types, defaults and alignment rule for the load/store unit
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        CAUSE_NONE           = 2'b00,
        CAUSE_LOAD_MISALIGN  = 2'b01,
        CAUSE_STORE_MISALIGN = 2'b10,
        CAUSE_STORE_TIMEOUT  = 2'b11
    } lsu_cause_t;

    localparam int LSU_STORE_TIMEOUT_DEFAULT = 16;

    // Size 11 is handled as a word, so anything other than byte/half needs full alignment.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic result;
        case (lsu_size_t'(size))
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = offset[0];
            default:   result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic        i_unsigned,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_byte_enable,
    output logic [31:0] o_store_data,
    output logic [31:0] o_load_result
);

    logic [15:0] w_lane;

    always_comb begin
        w_lane        = 16'(i_load_word >> {i_offset, 3'b000});
        o_byte_enable = 4'b1111;
        o_store_data  = i_wdata;
        o_load_result = i_load_word;
        case (lsu_size_t'(i_size))
            SIZE_BYTE: begin
                o_byte_enable = 4'b0001 << i_offset;
                o_store_data  = {4{i_wdata[7:0]}};
                o_load_result = {{24{w_lane[7] & ~i_unsigned}}, w_lane[7:0]};
            end
            SIZE_HALF: begin
                o_byte_enable = 4'b0011 << i_offset;
                o_store_data  = {2{i_wdata[15:0]}};
                o_load_result = {{16{w_lane[15] & ~i_unsigned}}, w_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - pipeline load/store sequencer driving the unified memory data port
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int STORE_TIMEOUT = LSU_STORE_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic [31:0] d_address,
    output logic [31:0] storeData,
    output logic [3:0]  byteEnable,
    output logic        storeValid,
    input  logic [31:0] loadData,
    input  logic        loadDataValid,
    input  logic        storeComplete
);

    localparam int CW = $clog2(STORE_TIMEOUT + 1);

    lsu_state_t    r_state;
    lsu_state_t    w_next_state;
    lsu_cause_t    r_cause;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic          r_fault;
    logic          r_flushed;
    logic [CW-1:0] r_count;

    logic          w_misaligned;
    logic          w_accept;
    logic          w_load_take;
    logic          w_timeout;
    logic [3:0]    w_byte_enable;
    logic [31:0]   w_store_data;
    logic [31:0]   w_load_result;

    assign w_misaligned = lsu_misaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .i_size        (r_size),
        .i_offset      (r_addr[1:0]),
        .i_wdata       (r_wdata),
        .i_unsigned    (r_unsigned),
        .i_load_word   (loadData),
        .o_byte_enable (w_byte_enable),
        .o_store_data  (w_store_data),
        .o_load_result (w_load_result)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A store already strobed cannot be withdrawn; a flush only suppresses its response.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_take  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && !flush) begin
                    w_accept = 1'b1;
                    if (w_misaligned) begin
                        w_next_state = DONE;
                    end else if (req_store) begin
                        w_next_state = STORE;
                    end else begin
                        w_next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (loadDataValid) begin
                    w_load_take  = 1'b1;
                    w_next_state = DONE;
                end
            end
            STORE: begin
                if (storeComplete || r_count == CW'(STORE_TIMEOUT - 1)) begin
                    w_timeout    = !storeComplete;
                    w_next_state = (flush || r_flushed) ? IDLE : DONE;
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_fault    <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_flushed  <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_rdata    <= '0;
                r_fault    <= w_misaligned;
                r_cause    <= !w_misaligned ? CAUSE_NONE :
                              req_store     ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                r_flushed  <= 1'b0;
                r_count    <= '0;
            end
            if (w_load_take) begin
                r_rdata <= w_load_result;
            end
            if (r_state == STORE) begin
                r_count <= r_count + 1'b1;
                if (flush) begin
                    r_flushed <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
                r_cause <= CAUSE_STORE_TIMEOUT;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign storeValid = (r_state == STORE);
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;
    assign resp_cause = r_cause;
    assign d_address  = r_addr;
    assign byteEnable = storeValid ? w_byte_enable : 4'b0000;
    assign storeData  = storeValid ? w_store_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench with behavioural memory and reference model
module tb_load_store_unit;

    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset, flush, req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic [31:0] d_address, storeData, loadData;
    logic [3:0]  byteEnable;
    logic        storeValid, loadDataValid, storeComplete;

    load_store_unit #(.STORE_TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .resp_cause(resp_cause),
        .d_address(d_address), .storeData(storeData), .byteEnable(byteEnable),
        .storeValid(storeValid), .loadData(loadData), .loadDataValid(loadDataValid),
        .storeComplete(storeComplete)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    assign loadData = mem[d_address[11:2]];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    logic [31:0] exp_rdata = '0, exp_sd = '0, exp_addr = '0;
    logic        exp_fault = 1'b0;
    logic [1:0]  exp_cause = '0;
    logic [3:0]  exp_be = '0;
    logic        sv_allowed = 1'b0, resp_expected = 1'b0, chk_en = 1'b0;
    logic [3:0]  last_be;
    logic [31:0] last_sd, last_rdata;
    logic        last_fault;
    logic [1:0]  last_cause;
    logic        sc_enable = 1'b1;
    int          sc_delay = 0, ld_mode = 1, n_pulses = 0, acc_cyc = 0;

    function automatic logic f_misal(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] word, input int off,
                                           input logic [1:0] sz, input logic un);
        longint v;
        if (sz == 2'd0) begin
            v = longint'((word >> (8 * off)) & 32'hFF);
            if (!un && v > 127) v = v - 256;
        end else if (sz == 2'd1) begin
            v = longint'((word >> (8 * off)) & 32'hFFFF);
            if (!un && v > 32767) v = v - 65536;
        end else begin
            v = longint'(word);
        end
        return v[31:0];
    endfunction

    task automatic model_setup(input logic st, input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] wd);
        int   off = int'(a % 4);
        logic mis = f_misal(sz, a);
        exp_addr      = a;
        resp_expected = 1'b1;
        exp_be = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'hF;
        exp_sd = (sz == 2'd0) ? wd[7:0] * 32'h01010101 :
                 (sz == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
        sv_allowed = st && !mis;
        exp_rdata  = '0;
        exp_fault  = 1'b0;
        exp_cause  = 2'd0;
        if (mis) begin
            exp_fault = 1'b1;
            exp_cause = st ? 2'd2 : 2'd1;
        end else if (st) begin
            if (sc_enable) begin
                for (int i = 0; i < 4; i++)
                    if (exp_be[i]) ref_mem[a[11:2]][8*i +: 8] = exp_sd[8*i +: 8];
            end else begin
                exp_fault = 1'b1;
                exp_cause = 2'd3;
            end
        end else begin
            exp_rdata = f_load(ref_mem[a[11:2]], off, sz, un);
        end
    endtask

    task automatic send_req(input logic st, input logic [1:0] sz, input logic un,
                            input logic [31:0] a, input logic [31:0] wd);
        int w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clock); #1; w++;
        end
        if (w >= 50) chk("req_ready_wait", 32'(req_ready), 1);
        req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output int lat);
        model_setup(st, sz, un, a, wd);
        send_req(st, sz, un, a, wd);
        lat = -1;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            @(negedge clock);
            if (resp_valid) lat = cyc - acc_cyc;
        end
        chk("resp_arrives", 32'(lat >= 0), 1);
        last_rdata = resp_rdata; last_fault = resp_fault; last_cause = resp_cause;
        repeat (hold) @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready    = 1'b0;
        resp_expected = 1'b0;
        sv_allowed    = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clock); #1;
            loadDataValid = (ld_mode == 1) ? 1'b1 : (ld_mode == 2) ? 1'($urandom % 2) : 1'b0;
        end
    end

    // Memory side: one storeComplete pulse per storeValid rising edge, writing enabled lanes.
    logic        m_prev = 1'b0;
    logic [3:0]  m_be;
    logic [31:0] m_sd, m_addr;
    initial begin
        storeComplete = 1'b0;
        forever begin
            @(negedge clock);
            if (storeValid && !m_prev && sc_enable) begin
                m_be = byteEnable; m_sd = storeData; m_addr = d_address;
                repeat (sc_delay) @(posedge clock);
                @(posedge clock); #1;
                storeComplete = 1'b1;
                n_pulses++;
                for (int i = 0; i < 4; i++)
                    if (m_be[i]) mem[m_addr[11:2]][8*i +: 8] = m_sd[8*i +: 8];
                @(posedge clock); #1;
                storeComplete = 1'b0;
                m_prev = 1'b1;
            end else begin
                m_prev = storeValid;
            end
        end
    end

    int   low_run = 0;
    logic c_seen = 1'b0, c_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                if (storeValid) begin
                    chk("store_allowed", 32'(sv_allowed), 1);
                    chk("byteEnable", 32'(byteEnable), 32'(exp_be));
                    chk("storeData", storeData, exp_sd);
                    chk("d_address", d_address, exp_addr);
                    last_be = byteEnable; last_sd = storeData;
                    if (!c_prev && c_seen) chk("store_gap_ge2", 32'(low_run >= 2), 1);
                    c_seen = 1'b1; low_run = 0;
                end else begin
                    chk("byteEnable_idle", 32'(byteEnable), 0);
                    low_run++;
                end
                c_prev = storeValid;
                if (resp_valid) begin
                    chk("resp_expected", 32'(resp_expected), 1);
                    chk("resp_rdata", resp_rdata, exp_rdata);
                    chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
                    chk("resp_cause", 32'(resp_cause), 32'(exp_cause));
                    chk("req_ready_in_done", 32'(req_ready), 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int          lat;
        logic [31:0] w;
        logic        st, un, mis;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        int          hold, p0;

        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        loadDataValid = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_fault", 32'(resp_fault), 0);
        chk("rst_resp_cause", 32'(resp_cause), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_d_address", d_address, 0);
        chk("rst_storeData", storeData, 0);
        chk("rst_byteEnable", 32'(byteEnable), 0);
        chk("rst_storeValid", 32'(storeValid), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;

        mem[64] = 32'h80FF7F01; ref_mem[64] = 32'h80FF7F01;
        ld_mode = 1;
        do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, lat);
        chk("lb_latency", 32'(lat), 1);
        chk("lb_signed_lit", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, lat);
        chk("lbu_lit", last_rdata, 32'h00000080);

        do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 0, lat);
        chk("sh_latency", 32'(lat), 2);
        chk("sh_be_lit", 32'(last_be), 32'b1100);
        chk("sh_sd_lit", last_sd, 32'hBEEFBEEF);
        w = mem[64];
        chk("sh_mem_hi", 32'(w[31:16]), 32'hBEEF);
        chk("sh_fault", 32'(last_fault), 0);

        p0 = n_pulses;
        do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 0, lat);
        chk("sw0_latency", 32'(lat), 2);
        do_req(1'b1, 2'd2, 1'b0, 32'h204, 32'h55667788, 0, lat);
        chk("sw1_latency", 32'(lat), 2);
        chk("b2b_pulses", 32'(n_pulses - p0), 2);
        chk("b2b_mem0", mem[128], 32'h11223344);
        chk("b2b_mem1", mem[129], 32'h55667788);

        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1, lat);
        chk("mis_ld_latency", 32'(lat), 0);
        chk("mis_ld_fault", 32'(last_fault), 1);
        chk("mis_ld_cause", 32'(last_cause), 1);
        do_req(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 0, lat);
        chk("mis_st_cause", 32'(last_cause), 2);

        sc_enable = 1'b0;
        do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF, 0, lat);
        chk("timeout_latency", 32'(lat), T);
        chk("timeout_fault", 32'(last_fault), 1);
        chk("timeout_cause", 32'(last_cause), 3);
        chk("timeout_mem", mem[192], ref_mem[192]);
        sc_enable = 1'b1;

        model_setup(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        resp_expected = 1'b0;
        req_store = 1'b0; req_size = 2'd2; req_addr = 32'h0; req_valid = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        chk("flush_idle_ready", 32'(req_ready), 1);

        ld_mode = 0;
        model_setup(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        resp_expected = 1'b0;
        send_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; ld_mode = 1;
        repeat (4) @(negedge clock);
        chk("flush_load_ready", 32'(req_ready), 1);

        sc_delay = 0;
        model_setup(1'b1, 2'd2, 1'b0, 32'h208, 32'hCAFEF00D);
        resp_expected = 1'b0;
        send_req(1'b1, 2'd2, 1'b0, 32'h208, 32'hCAFEF00D);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        repeat (5) @(negedge clock);
        sv_allowed = 1'b0;
        chk("flush_store_mem", mem[130], 32'hCAFEF00D);
        chk("flush_store_ready", 32'(req_ready), 1);

        model_setup(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        send_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; resp_expected = 1'b0;
        @(negedge clock);
        chk("flush_done_drop", 32'(resp_valid), 0);

        sc_delay = 2;
        model_setup(1'b1, 2'd2, 1'b0, 32'h20C, 32'h0BADC0DE);
        resp_expected = 1'b0;
        send_req(1'b1, 2'd2, 1'b0, 32'h20C, 32'h0BADC0DE);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        sv_allowed = 1'b0;
        chk("rst_store_sv", 32'(storeValid), 0);
        chk("rst_store_ready", 32'(req_ready), 1);
        chk("rst_store_addr", d_address, 0);
        repeat (6) @(negedge clock);
        chk("rst_store_ignore_complete", 32'(req_ready), 1);
        sc_delay = 0;

        ld_mode = 2;
        for (int t = 0; t < 200; t++) begin
            st = 1'($urandom % 2); sz = 2'($urandom % 4); un = 1'($urandom % 2);
            a = $urandom % 4096; wd = $urandom;
            sc_delay = $urandom % 3; hold = $urandom % 3;
            sc_enable = ($urandom % 16) != 0;
            mis = f_misal(sz, a);
            do_req(st, sz, un, a, wd, hold, lat);
            if (mis) chk("rand_mis_latency", 32'(lat), 0);
            if (st && !mis) chk("rand_mem", mem[a[11:2]], ref_mem[a[11:2]]);
        end
        sc_enable = 1'b1;

        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
